pipe_stage_reg: RTL

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It is the successor to the fixed-field inter-stage registers: the payload is one packed vector, stall is expressed through backpressure instead of a separate enable, and bubbles are tracked by a valid bit. Instances sit between IF/ID/EX/MEM/WB. Hazard logic drives `out_ready` low to stall and drives `flush` to kill the stage.

---
 rtl/pipe_stage_reg.sv | 74 +++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with sync flush.
// Define PIPE_STAGE_REG_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int DW = 128,
  parameter logic [DW-1:0] FLUSH_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occ
);
  logic          mv_q, mv_d, in_x, out_x;
  logic [DW-1:0] main_q, main_d;
`ifdef PIPE_STAGE_REG_SKID_EN
  logic          sv_q, sv_d, rdy_q, to_skid;
  logic [1:0]    occ_q;
  logic [DW-1:0] skid_q, skid_d;
  always_comb begin
    in_x    = in_valid & rdy_q;
    out_x   = mv_q & out_ready;
    // a new payload parks in the skid entry only when main is held by a stall
    to_skid = in_x & mv_q & ~out_x & ~sv_q;
    main_d  = sv_q ? (out_x ? skid_q : main_q) : ((in_x & ~to_skid) ? in_data : main_q);
    mv_d    = sv_q | in_x | (mv_q & ~out_x);
    sv_d    = (sv_q & ~out_x) | to_skid;
    skid_d  = to_skid ? in_data : skid_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      mv_q   <= 1'b0;
      sv_q   <= 1'b0;
      rdy_q  <= 1'b1;
      occ_q  <= 2'd0;
      main_q <= FLUSH_VAL;
      skid_q <= FLUSH_VAL;
    end else begin
      mv_q   <= mv_d;
      sv_q   <= sv_d;
      rdy_q  <= ~sv_d;
      occ_q  <= {1'b0, mv_d} + {1'b0, sv_d};
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  assign in_ready = rdy_q;
  assign occ      = occ_q;
`else
  always_comb begin
    out_x  = mv_q & out_ready;
    in_x   = in_valid & (~mv_q | out_ready);
    main_d = in_x ? in_data : main_q;
    mv_d   = in_x | (mv_q & ~out_x);
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      mv_q   <= 1'b0;
      main_q <= FLUSH_VAL;
    end else begin
      mv_q   <= mv_d;
      main_q <= main_d;
    end
  end
  assign in_ready = ~mv_q | out_ready;
  assign occ      = {1'b0, mv_q};
`endif
  assign out_valid = mv_q;
  assign out_data  = main_q;
endmodule
